// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared constants and types for the Modbus RTU transmit path and the
// planned receive checker: CRC-16/MODBUS polynomial and seed, frame length,
// frame-builder state encoding and a one-bit CRC step helper.
// -----------------------------------------------------------------------------
package modbus_pkg;

    localparam logic [15:0] CRC_POLY    = 16'hA001;   // reflected 0x8005
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam int          FRAME_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SEND,
        WAIT,
        NEXT,
        GAP
    } state_t;

    // One LSB-first shift of the CRC register.
    function automatic logic [15:0] crc_step(input logic [15:0] c);
        return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    endfunction

endpackage

// File: rtl/modbus_crc16_serial.sv
// -----------------------------------------------------------------------------
// modbus_crc16_serial
// Bit-serial CRC-16/MODBUS engine. A byte is folded in with load_i, then
// eight shift_en_i cycles complete it. Shared with the Modbus receive checker.
//
// Ports:
//   CLK, RSTn   clock, async active-low reset
//   init_i      reseed the register with CRC_INIT
//   load_i      XOR byte_i into the low byte of the register
//   byte_i      byte to fold in on load_i
//   shift_en_i  perform one shift step
//   crc_o       current CRC register
//   done_o      high during the cycle whose shift is the 8th since load_i
// -----------------------------------------------------------------------------
module modbus_crc16_serial
    import modbus_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        init_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    input  logic        shift_en_i,
    output logic [15:0] crc_o,
    output logic        done_o
);

    logic [15:0] crc_q;
    logic [2:0]  cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            crc_q <= CRC_INIT;
            cnt_q <= 3'd0;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
            cnt_q <= 3'd0;
        end else if (load_i) begin
            crc_q <= crc_q ^ {8'h00, byte_i};
            cnt_q <= 3'd0;
        end else if (shift_en_i) begin
            crc_q <= crc_step(crc_q);
            cnt_q <= cnt_q + 3'd1;   // wraps to 0 after the 8th shift
        end
    end

    assign crc_o  = crc_q;
    assign done_o = shift_en_i && (cnt_q == 3'd7);

endmodule

// File: rtl/modbus_frame_builder.sv
// -----------------------------------------------------------------------------
// modbus_frame_builder
// Builds one 8-byte Modbus RTU frame (ADDR, FUNC, 4 payload bytes, CRC lo,
// CRC hi) per request and hands it byte by byte to the UART byte transmitter,
// then enforces an inter-frame silence of GAP_CLKS cycles.
//
// Ports:
//   CLK, RSTn        clock, async active-low reset
//   Req_Sig          frame request, sampled only in IDLE
//   Data_In          payload, [31:24] sent first
//   TX_Done_Sig      byte transmitter finished the current byte
//   TX_En_Sig        byte transmitter enable (level)
//   TX_Data          byte to transmit, stable while TX_En_Sig is high
//   Busy_Sig         frame in progress (acceptance through end of gap)
//   Frame_Done_Sig   one-cycle pulse after the last byte completes
//   CRC_Out          CRC of the last completed frame
//
// state | meaning
// IDLE  | waiting for Req_Sig
// LOAD  | select byte idx; fold data bytes into the CRC
// SHIFT | eight CRC shift cycles
// SEND  | present byte, raise TX_En_Sig
// WAIT  | hold byte until TX_Done_Sig
// NEXT  | advance idx or finish the frame
// GAP   | inter-frame silence
// -----------------------------------------------------------------------------
module modbus_frame_builder
    import modbus_pkg::*;
#(
    parameter logic [7:0]  ADDR     = 8'h02,
    parameter logic [7:0]  FUNC     = 8'h02,
    parameter logic [15:0] GAP_CLKS = 16'd1000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req_Sig,
    input  logic [31:0] Data_In,
    input  logic        TX_Done_Sig,
    output logic        TX_En_Sig,
    output logic [7:0]  TX_Data,
    output logic        Busy_Sig,
    output logic        Frame_Done_Sig,
    output logic [15:0] CRC_Out
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    state_t      state_q;
    logic [31:0] data_q;
    logic [2:0]  idx_q;
    logic [15:0] gap_q;
    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        frame_done_q;
    logic [15:0] crc_out_q;

    logic [7:0]  cur_byte;
    logic [15:0] crc;
    logic        crc_init;
    logic        crc_load;
    logic        crc_shift;
    logic        crc_done;

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0:    cur_byte = ADDR;
            3'd1:    cur_byte = FUNC;
            3'd2:    cur_byte = data_q[31:24];
            3'd3:    cur_byte = data_q[23:16];
            3'd4:    cur_byte = data_q[15:8];
            3'd5:    cur_byte = data_q[7:0];
            3'd6:    cur_byte = crc[7:0];
            default: cur_byte = crc[15:8];
        endcase
    end

    // CRC bytes are not folded into the CRC itself.
    assign crc_init  = (state_q == IDLE) && Req_Sig;
    assign crc_load  = (state_q == LOAD) && (idx_q <= 3'd5);
    assign crc_shift = (state_q == SHIFT);

    modbus_crc16_serial u_crc (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .init_i     (crc_init),
        .load_i     (crc_load),
        .byte_i     (cur_byte),
        .shift_en_i (crc_shift),
        .crc_o      (crc),
        .done_o     (crc_done)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            data_q       <= 32'h0;
            idx_q        <= 3'd0;
            gap_q        <= 16'd0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            crc_out_q    <= 16'h0000;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req_Sig) begin
                        data_q    <= Data_In;
                        idx_q     <= 3'd0;
                        busy_q    <= 1'b1;
                        crc_out_q <= 16'h0000;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= (idx_q <= 3'd5) ? SHIFT : SEND;
                end
                SHIFT: begin
                    if (crc_done) state_q <= SEND;
                end
                SEND: begin
                    tx_data_q <= cur_byte;
                    tx_en_q   <= 1'b1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // Dropping enable here guarantees a low cycle between bytes.
                    if (TX_Done_Sig) begin
                        tx_en_q <= 1'b0;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        crc_out_q    <= crc;
                        frame_done_q <= 1'b1;
                        gap_q        <= GAP_CLKS;
                        state_q      <= GAP;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= LOAD;
                    end
                end
                GAP: begin
                    // GAP_CLKS cycles in GAP; zero still spends one cycle here.
                    if (gap_q <= 16'd1) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TX_En_Sig      = tx_en_q;
    assign TX_Data        = tx_data_q;
    assign Busy_Sig       = busy_q;
    assign Frame_Done_Sig = frame_done_q;
    assign CRC_Out        = crc_out_q;

endmodule

// File: tb/tb_modbus_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_modbus_frame_builder
// Directed bench for modbus_frame_builder with a simple byte-TX responder
// that records every byte, checks TX_Data stability and the low enable gap.
// -----------------------------------------------------------------------------
module tb_modbus_frame_builder;

    localparam logic [63:0] FRAME_A = 64'h0103_0000_000A_C5CD;
    localparam logic [15:0] CRC_A   = 16'hCDC5;
    localparam logic [63:0] FRAME_B = 64'h0103_0000_0001_840A;
    localparam logic [15:0] CRC_B   = 16'h0A84;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Req_Sig = 1'b0;
    logic [31:0] Data_In = 32'h0;
    logic        TX_Done_Sig;
    logic        TX_En_Sig;
    logic [7:0]  TX_Data;
    logic        Busy_Sig;
    logic        Frame_Done_Sig;
    logic [15:0] CRC_Out;

    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign TX_Done_Sig = model_done | spur_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] byte_q[$];
    int         stab_err = 0;
    int         gap_err  = 0;
    int         done_delay = 10;
    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] m_cap = 8'h00;

    modbus_frame_builder #(
        .ADDR     (8'h01),
        .FUNC     (8'h03),
        .GAP_CLKS (16'd20)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Req_Sig        (Req_Sig),
        .Data_In        (Data_In),
        .TX_Done_Sig    (TX_Done_Sig),
        .TX_En_Sig      (TX_En_Sig),
        .TX_Data        (TX_Data),
        .Busy_Sig       (Busy_Sig),
        .Frame_Done_Sig (Frame_Done_Sig),
        .CRC_Out        (CRC_Out)
    );

    always #5 CLK = ~CLK;

    // Byte-TX responder: 0 idle, 1 byte in flight, 2 just answered Done.
    initial begin
        forever begin
            @(negedge CLK);
            model_done = 1'b0;
            if (m_state == 0 && TX_En_Sig) begin
                m_cap = TX_Data;
                byte_q.push_back(TX_Data);
                m_cnt = done_delay;
                m_state = 1;
            end
            if (m_state == 1) begin
                if (!TX_En_Sig) begin
                    m_state = 0;
                end else begin
                    if (TX_Data !== m_cap) stab_err++;
                    if (m_cnt == 0) begin
                        model_done = 1'b1;
                        m_state = 2;
                    end else begin
                        m_cnt--;
                    end
                end
            end else if (m_state == 2) begin
                if (TX_En_Sig) gap_err++;
                m_state = 0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input logic [31:0] data, input int delay,
                             input logic [63:0] exp_bytes, input logic [15:0] exp_crc,
                             input bit spur_in_shift, input string name);
        int n;
        int fd_cnt;
        logic [7:0] got;
        logic [7:0] exp;
        byte_q.delete();
        stab_err = 0;
        gap_err = 0;
        done_delay = delay;
        fd_cnt = 0;
        Data_In = data;
        Req_Sig = 1'b1;
        @(negedge CLK);
        Req_Sig = 1'b0;
        Data_In = ~data;
        if (spur_in_shift) begin
            @(negedge CLK);
            spur_done = 1'b1;
            repeat (6) @(negedge CLK);
            spur_done = 1'b0;
        end
        n = 0;
        while (!Frame_Done_Sig && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (n >= 20000) begin
            n_err++;
            $display("FAIL %s_timeout: got no Frame_Done_Sig, expected one", name);
        end else begin
            fd_cnt = 1;
        end
        n = 0;
        while (Busy_Sig && n < 5000) begin
            @(negedge CLK);
            n++;
            if (Frame_Done_Sig) fd_cnt++;
        end
        n_cmp++;
        if (byte_q.size() != 8) begin
            n_err++;
            $display("FAIL %s_count: got %0d bytes, expected 8", name, byte_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            exp = exp_bytes[63 - 8*i -: 8];
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s_byte%0d: got %h, expected %h", name, i, got, exp);
            end
        end
        n_cmp++;
        if (CRC_Out !== exp_crc) begin
            n_err++;
            $display("FAIL %s_crc: got %h, expected %h", name, CRC_Out, exp_crc);
        end
        n_cmp++;
        if (fd_cnt != 1) begin
            n_err++;
            $display("FAIL %s_done_pulses: got %0d, expected 1", name, fd_cnt);
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_err++;
            $display("FAIL %s_data_stable: got %0d changes, expected 0", name, stab_err);
        end
        n_cmp++;
        if (gap_err != 0) begin
            n_err++;
            $display("FAIL %s_en_gap: got %0d missing low cycles, expected 0", name, gap_err);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (TX_En_Sig !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b, expected 0", TX_En_Sig); end
        n_cmp++;
        if (TX_Data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, expected 00", TX_Data); end
        n_cmp++;
        if (Busy_Sig !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", Busy_Sig); end
        n_cmp++;
        if (Frame_Done_Sig !== 1'b0) begin n_err++; $display("FAIL rst_fdone: got %b, expected 0", Frame_Done_Sig); end
        n_cmp++;
        if (CRC_Out !== 16'h0000) begin n_err++; $display("FAIL rst_crc: got %h, expected 0000", CRC_Out); end
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic();
        run_frame(32'h0000000A, 10, FRAME_A, CRC_A, 1'b0, "frame_a");
        run_frame(32'h00000001, 10, FRAME_B, CRC_B, 1'b0, "frame_b");
    endtask

    task automatic test_done_timing();
        run_frame(32'h0000000A, 0, FRAME_A, CRC_A, 1'b0, "done_now");
        run_frame(32'h00000001, 500, FRAME_B, CRC_B, 1'b0, "done_slow");
    endtask

    task automatic test_req_held();
        int n;
        bit saw_low;
        byte_q.delete();
        stab_err = 0;
        gap_err = 0;
        done_delay = 3;
        Data_In = 32'h0000000A;
        Req_Sig = 1'b1;
        n = 0;
        while (!Frame_Done_Sig && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (byte_q.size() != 8) begin
            n_err++;
            $display("FAIL held_first_count: got %0d bytes, expected 8", byte_q.size());
        end
        saw_low = 1'b0;
        n = 0;
        while (!(saw_low && Busy_Sig) && n < 200) begin
            @(negedge CLK);
            n++;
            if (!Busy_Sig) saw_low = 1'b1;
        end
        n_cmp++;
        if (!(saw_low && n >= 20 && n < 200)) begin
            n_err++;
            $display("FAIL held_gap: got restart after %0d cycles (busy fell %b), expected >= 20", n, saw_low);
        end
        Req_Sig = 1'b0;
        n = 0;
        while (!Frame_Done_Sig && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (Busy_Sig && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (byte_q.size() != 16) begin
            n_err++;
            $display("FAIL held_total_count: got %0d bytes, expected 16", byte_q.size());
        end
        n_cmp++;
        if (byte_q.size() == 16 && (byte_q[14] !== 8'hC5 || byte_q[15] !== 8'hCD)) begin
            n_err++;
            $display("FAIL held_second_crc: got %h %h, expected c5 cd", byte_q[14], byte_q[15]);
        end
        n_cmp++;
        if (Busy_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL held_idle: got busy %b, expected 0", Busy_Sig);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int n;
        byte_q.delete();
        done_delay = 200;
        Data_In = 32'h00000001;
        Req_Sig = 1'b1;
        @(negedge CLK);
        Req_Sig = 1'b0;
        n = 0;
        while (byte_q.size() < 4 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if (TX_En_Sig !== 1'b0) begin n_err++; $display("FAIL midrst_en: got %b, expected 0", TX_En_Sig); end
        n_cmp++;
        if (Busy_Sig !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, expected 0", Busy_Sig); end
        n_cmp++;
        if (CRC_Out !== 16'h0000) begin n_err++; $display("FAIL midrst_crc: got %h, expected 0000", CRC_Out); end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        run_frame(32'h0000000A, 10, FRAME_A, CRC_A, 1'b0, "after_rst");
    endtask

    task automatic test_spurious();
        repeat (3) begin
            spur_done = 1'b1;
            @(negedge CLK);
            spur_done = 1'b0;
            @(negedge CLK);
        end
        n_cmp++;
        if (Busy_Sig !== 1'b0) begin n_err++; $display("FAIL spur_idle_busy: got %b, expected 0", Busy_Sig); end
        n_cmp++;
        if (TX_En_Sig !== 1'b0) begin n_err++; $display("FAIL spur_idle_en: got %b, expected 0", TX_En_Sig); end
        run_frame(32'h0000000A, 10, FRAME_A, CRC_A, 1'b1, "spur_shift");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_timing();
        test_req_held();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
